cla_pipe_adder: RTL and testbench
=================================

// Module: cla_pipe_adder
// PURPOSE
//  Pipelined XLEN-bit add/subtract unit for the rv_64im ALU datapath; sits directly downstream of fourbit_cla.
//  Consumes the per-bit g/p vectors of XLEN/4 fourbit_cla slices and forms group and block lookahead carries.
//  Re-drives the slices with true carry-ins; registers sum and flags behind valid/ready handshakes.
//  Serves ADD/SUB/ADDW/SUBW and address generation.
// PARAMETERS
//  XLEN     64  operand width; legal values 32 or 64 (multiple of 16)
//  W_MODE   1   1 = word ops (ADDW/SUBW) supported; forced to 0 when XLEN=32
// PORTS
//  clk        in   1     single clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  flush      in   1     synchronous kill of all in-flight ops
//  in_valid   in   1     operand beat valid
//  in_ready   out  1     unit can accept operand beat
//  in_a       in   XLEN  operand A
//  in_b       in   XLEN  operand B
//  in_sub     in   1     1 = A - B (B inverted, carry-in 1)
//  in_word    in   1     1 = 32-bit op, result sign-extended from bit 31
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer accepts result
//  out_sum    out  XLEN  result
//  out_cout   out  1     carry out of bit XLEN-1 (bit 31 in word mode)
//  out_ovf    out  1     signed overflow at the same MSB
//  out_zero   out  1     out_sum == 0 after sign extension
// BEHAVIOUR
//  Reset: all stage-valid flops and out_valid=0; out_sum=0; out_cout=0; out_ovf=0; out_zero=0. in_ready=1 after reset.
//  Handshake: beat transfers when valid&ready on the same edge. out_* hold stable while out_valid & !out_ready.
//  Latency: 2 cycles from accept to out_valid, no stalls. Throughput: 1 op/cycle.
//  S1 (accept edge): registers A and B^{XLEN{sub}}, cin=sub, word, and group G/P for each 4-bit slice.
//    Group G/P are formed from the fourbit_cla g/p as G=g3|p3g2|p3p2g1|p3p2p1g0, P=&p.
//  S2 (next edge): 2-level lookahead: 4 groups -> 16-bit block G/P -> block carries, cin rippled in lookahead form.
//    Each slice gets its carry-in; slice sums are assembled into the result.
//    Result, cout and ovf (= c_in_msb ^ c_out_msb) are registered into the output flops.
//  Word mode: carry chain is cut at bit 31; out_sum[63:32] = {32{sum[31]}}; out_cout/ovf taken at bit 31.
//    Upper operand bits are ignored.
//  Stall: in_ready = !s1_valid | !out_valid | out_ready. Stage advance is bubble-collapsing:
//    S1 moves to S2 whenever S2 is empty or draining.
//  Full: both stages valid and !out_ready -> in_ready=0; no state changes.
//  Simultaneous events:
//    - Accept + drain on the same edge: all three transfers occur; no bubble is inserted.
//    - flush: s1_valid and out_valid cleared next edge; in_ready is ignored and any same-cycle input beat is dropped.
//      flush has priority over out_ready.
//  Reset mid-operation: in-flight ops are lost. Outputs go to reset values asynchronously.
//  Arithmetic wraps modulo 2^XLEN (2^32 in word mode); no saturation.
//  Datapath flops are not reset except the output flops. Only the valid flops are required for correctness.
// STRUCTURE
//  Shared include adder_defs.vh holds:
//    - localparam ADD_SLICE_W=4
//    - ADD_GRP_PER_BLK=4
//    - XLEN legality check macro
//    - op-bit positions for the {word,sub} ALU field
//  Sub-module cla_lookahead4: 4x(G,P)+cin -> 4 carries + block G/P. It is instantiated per group level.
//  fourbit_cla slices are instantiated twice per slice position:
//    - S1 instance with c=0, used for g/p only
//    - S2 instance with true carry
//  Top holds the two pipeline stages, handshake logic and flag generation.
// TESTING
//  1. A=64'h7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> cycle+2:
//     sum=64'h8000_0000_0000_0000, cout=0, ovf=1, zero=0.
//  2. A=5, B=5, sub=1 -> sum=0, cout=1, zero=1, ovf=0.
//     A=0, B=1, sub=1 -> sum=all-ones, cout=0.
//  3. word=1, A=64'hDEAD_0000_7FFF_FFFF, B=1 -> sum=64'hFFFF_FFFF_8000_0000, ovf=1, cout=0.
//  4. Back-to-back 8 beats, out_ready=0 for cycles 3-6:
//     - in_ready drops once 2 ops are held
//     - out_* stable during the stall
//     - all 8 results delivered in order, none lost or duplicated
//  5. flush asserted with both stages full and in_valid=1 -> next cycle out_valid=0, in_ready=1.
//     The flushed beat never appears at the output.
//  6. rst_n pulsed low mid-stream (asynchronous, between edges) -> out_valid and flags 0 immediately.
//     The first post-reset op returns the correct sum 2 cycles after accept.
//  Random: 10k random A/B/sub/word with random in_valid/out_ready -> match reference model.

Source files
------------

// File: rtl/cla_pipe_adder_pkg.sv
// cla_pipe_adder_pkg: shared slice/group sizing, ALU op field layout and group G/P helper
package cla_pipe_adder_pkg;
  localparam int ADD_SLICE_W     = 4;
  localparam int ADD_GRP_PER_BLK = 4;
  typedef struct packed {
    logic word;
    logic sub;
  } add_op_t;
  function automatic logic [1:0] grp_gp(input logic [3:0] g, input logic [3:0] p);
    return {g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0], &p};
  endfunction
endpackage

// File: rtl/cla_lookahead4.sv
// cla_lookahead4: four (G,P) pairs plus carry-in to per-position carry-ins and combined block G/P
module cla_lookahead4
  import cla_pipe_adder_pkg::*;
(
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [3:0] c,
  output logic       bg,
  output logic       bp
);
  assign c[0]     = cin;
  assign c[1]     = g[0] | p[0] & cin;
  assign c[2]     = g[1] | p[1] & g[0] | p[1] & p[0] & cin;
  assign c[3]     = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & cin;
  assign {bg, bp} = grp_gp(g, p);
endmodule

// File: rtl/fourbit_cla.sv
// fourbit_cla: 4-bit lookahead slice exposing per-bit generate/propagate
module fourbit_cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] s,
  output logic [3:0] g,
  output logic [3:0] p
);
  logic [3:0] cy;
  assign g     = a & b;
  assign p     = a ^ b;
  assign cy[0] = c;
  assign cy[1] = g[0] | p[0] & c;
  assign cy[2] = g[1] | p[1] & g[0] | p[1] & p[0] & c;
  assign cy[3] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & c;
  assign s     = p ^ cy;
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined lookahead add/sub with word mode and valid/ready handshakes
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int W_MODE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            in_sub,
  input  logic            in_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_sum,
  output logic            out_cout,
  output logic            out_ovf,
  output logic            out_zero
);
  localparam int NG      = XLEN / ADD_SLICE_W;
  localparam int NB      = NG / ADD_GRP_PER_BLK;
  localparam bit WORD_EN = (XLEN > 32) && (W_MODE != 0);
  logic            s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  add_op_t         op_q, op_d;
  logic [NG-1:0]   grp_g_q, grp_g_d, grp_p_q, grp_p_d, grp_cin;
  logic            cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [XLEN-1:0] b_in, s1_g, s1_p, s1_sum_unused, s2_g_unused, s2_p_unused, sum, res;
  logic [NB-1:0]   blk_g, blk_p;
  logic [3:0]      bg4, bp4, top_c;
  logic            top_g, top_p, cout_full, c32, accept, s1_adv;
  assign in_ready = !s1_valid_q | !out_valid_q | out_ready;
  assign accept   = in_valid & in_ready & !flush;
  assign s1_adv   = s1_valid_q & (!out_valid_q | out_ready) & !flush;
  assign b_in     = in_b ^ {XLEN{in_sub}};
  for (genvar i = 0; i < NG; i++) begin : g_slice
    fourbit_cla u_s1 (.a(in_a[4*i+:4]), .b(b_in[4*i+:4]), .c(1'b0), .s(s1_sum_unused[4*i+:4]),
                      .g(s1_g[4*i+:4]), .p(s1_p[4*i+:4]));
    fourbit_cla u_s2 (.a(a_q[4*i+:4]), .b(b_q[4*i+:4]), .c(grp_cin[i]), .s(sum[4*i+:4]),
                      .g(s2_g_unused[4*i+:4]), .p(s2_p_unused[4*i+:4]));
  end
  // Groups resolve inside each 16-bit block; blocks resolve at the top level.
  for (genvar b = 0; b < NB; b++) begin : g_blk
    cla_lookahead4 u_l1 (.g(grp_g_q[4*b+:4]), .p(grp_p_q[4*b+:4]), .cin(top_c[b]),
                         .c(grp_cin[4*b+:4]), .bg(blk_g[b]), .bp(blk_p[b]));
  end
  always_comb begin
    bg4         = '0;
    bp4         = '0;
    bg4[NB-1:0] = blk_g;
    bp4[NB-1:0] = blk_p;
  end
  cla_lookahead4 u_l2 (.g(bg4), .p(bp4), .cin(op_q.sub), .c(top_c), .bg(top_g), .bp(top_p));
  assign cout_full = top_g | top_p & op_q.sub;
  if (XLEN > 32) begin : g_c32
    assign c32 = grp_cin[32/ADD_SLICE_W];
  end else begin : g_c32_full
    assign c32 = cout_full;
  end
  always_comb begin
    a_d         = accept ? in_a : a_q;
    b_d         = accept ? b_in : b_q;
    op_d        = accept ? add_op_t'{word: in_word & WORD_EN, sub: in_sub} : op_q;
    for (int i = 0; i < NG; i++)
      {grp_g_d[i], grp_p_d[i]} = accept ? grp_gp(s1_g[4*i+:4], s1_p[4*i+:4]) : {grp_g_q[i], grp_p_q[i]};
    res         = op_q.word ? XLEN'($signed(sum[31:0])) : sum;
    sum_d       = s1_adv ? res : sum_q;
    cout_d      = s1_adv ? (op_q.word ? c32 : cout_full) : cout_q;
    ovf_d       = s1_adv ? (op_q.word ? c32 ^ sum[31] ^ a_q[31] ^ b_q[31]
                                      : cout_full ^ sum[XLEN-1] ^ a_q[XLEN-1] ^ b_q[XLEN-1]) : ovf_q;
    zero_d      = s1_adv ? (res == '0) : zero_q;
    s1_valid_d  = !flush & (accept | (s1_valid_q & !s1_adv));
    out_valid_d = !flush & (s1_adv | (out_valid_q & !out_ready));
  end
  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    op_q    <= op_d;
    grp_g_q <= grp_g_d;
    grp_p_q <= grp_p_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed table, stall/flush/reset sequences and random traffic against an arithmetic model
module tb_cla_pipe_adder;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_sub = 0, in_word = 0, out_ready = 0;
  logic [63:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_cout, out_ovf, out_zero;
  logic [63:0] out_sum;
  typedef struct packed {logic [63:0] sum; logic cout; logic ovf; logic zero;} res_t;
  typedef struct packed {logic [63:0] a; logic [63:0] b; logic sub; logic word; res_t exp;} vec_t;
  int errors = 0, checks = 0, delivered = 0;
  res_t q[$];
  vec_t vecs[11];

  cla_pipe_adder #(.XLEN(64), .W_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_word(in_word), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero));

  always #5 clk = ~clk;

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic sub, input logic word);
    res_t r;
    logic [63:0] bb;
    logic [64:0] t;
    logic [32:0] t32;
    bb = sub ? ~b : b;
    if (word) begin
      t32    = {1'b0, a[31:0]} + {1'b0, bb[31:0]} + 33'(sub);
      r.sum  = {{32{t32[31]}}, t32[31:0]};
      r.cout = t32[32];
      r.ovf  = (a[31] == bb[31]) && (t32[31] != a[31]);
    end else begin
      t      = {1'b0, a} + {1'b0, bb} + 65'(sub);
      r.sum  = t[63:0];
      r.cout = t[64];
      r.ovf  = (a[63] == bb[63]) && (t[63] != a[63]);
    end
    r.zero = (r.sum == 64'd0);
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'hFFFF_FFFF_FFFF_FFFF;
      1: return 64'h7FFF_FFFF_FFFF_FFFF ^ 64'($urandom_range(0, 1));
      2: return 64'($urandom_range(0, 3));
      3: return {$urandom, 32'h7FFF_FFFF ^ 32'($urandom_range(0, 1))};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    res_t cur, held;
    logic held_v;
    held_v = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        held_v = 0;
      end else begin
        cur = {out_sum, out_cout, out_ovf, out_zero};
        if (held_v && out_valid) chk("hold_stable", 70'(cur), 70'(held));
        if (out_valid && out_ready && !flush) begin
          delivered++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h expected none", cur);
          end else chk("result", 70'(cur), 70'(q.pop_front()));
        end
        held_v = out_valid && !out_ready && !flush;
        held   = cur;
        if (flush) q.delete();
        else if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_sub, in_word));
      end
    end
  end

  task automatic run_vec(input vec_t v, input string name);
    @(posedge clk); #1;
    {in_a, in_b, in_sub, in_word} = {v.a, v.b, v.sub, v.word};
    in_valid  = 1;
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    chk({name, "_early"}, 70'(out_valid), 70'(0));
    @(posedge clk); #1;
    chk({name, "_valid"}, 70'(out_valid), 70'(1));
    chk(name, 70'({out_sum, out_cout, out_ovf, out_zero}), 70'(v.exp));
  endtask

  task automatic drain(input string name);
    int n;
    in_valid  = 0;
    out_ready = 1;
    for (n = 0; n < 30 && (q.size() != 0 || out_valid); n++) @(posedge clk);
    #1;
    chk(name, 70'(q.size()), 70'(0));
  endtask

  initial begin : timeout
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    logic [63:0] sa[8], sb[8];
    int i, cyc, d0, n;
    logic saw_full, acc, seen;
    vecs[0]  = {64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = {64'd5, 64'd5, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = {64'd0, 64'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = {64'hDEAD_0000_7FFF_FFFF, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = {64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = {64'h1234_0000_0000_0005, 64'hFFFF_0000_0000_0005, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = {64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[7]  = {64'hAAAA_AAAA_FFFF_FFFF, 64'h5555_5555_0000_0001, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = {64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = {64'h0000_0000_8000_0000, 64'd1, 1'b1, 1'b1, 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 70'({out_valid, in_ready, out_sum, out_cout, out_ovf, out_zero}),
        70'({1'b0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b0}));
    rst_n = 1;
    for (int k = 0; k < 11; k++) run_vec(vecs[k], $sformatf("vec%0d", k));
    drain("vec_drain");
    for (int k = 0; k < 8; k++) begin
      sa[k] = rnd64();
      sb[k] = rnd64();
    end
    i = 0; cyc = 0; saw_full = 0; d0 = delivered;
    @(posedge clk); #1;
    while (i < 8 && cyc < 100) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = 1;
      {in_a, in_b, in_sub, in_word} = {sa[i], sb[i], sa[i][0], sb[i][1]};
      @(negedge clk);
      acc = in_ready;
      if (!in_ready) saw_full = 1;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    drain("stall_drain");
    chk("stall_full_seen", 70'(saw_full), 70'(1));
    chk("stall_delivered", 70'(delivered - d0), 70'(8));
    @(posedge clk); #1;
    out_ready = 0;
    in_valid  = 1;
    {in_a, in_b, in_sub, in_word} = {rnd64(), rnd64(), 1'b0, 1'b0};
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!in_ready) break;
      @(posedge clk); #1;
      {in_a, in_b} = {rnd64(), rnd64()};
    end
    chk("flush_full", 70'(in_ready), 70'(0));
    @(posedge clk); #1;
    flush = 1;
    @(posedge clk); #1;
    flush    = 0;
    in_valid = 0;
    chk("flush_state", 70'({out_valid, in_ready}), 70'({1'b0, 1'b1}));
    out_ready = 1;
    seen      = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("flush_quiet", 70'(seen), 70'(0));
    @(posedge clk); #1;
    out_ready = 0;
    {in_a, in_b, in_sub, in_word} = {64'd5, 64'd5, 1'b1, 1'b0};
    in_valid = 1;
    @(posedge clk); #1;
    {in_a, in_b, in_sub} = {64'd9, 64'd3, 1'b0};
    @(posedge clk); #1;
    in_valid = 0;
    chk("pre_reset", 70'({out_valid, out_cout, out_zero}), 70'(3'b111));
    #2;
    rst_n = 0;
    #1;
    chk("reset_async", 70'({out_valid, out_sum, out_cout, out_ovf, out_zero}), 70'(0));
    chk("reset_ready", 70'(in_ready), 70'(1));
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1;
    run_vec(vecs[6], "post_reset");
    drain("reset_drain");
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) == 0);
      in_sub    = 1'($urandom_range(0, 1));
      in_word   = ($urandom_range(0, 9) < 3);
      in_a      = rnd64();
      in_b      = rnd64();
    end
    @(posedge clk); #1;
    flush = 0;
    drain("random_drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
